// File: rtl/buck_pkg.sv
// Shared types and constants for the buck converter control loop blocks.
package buck_pkg;

    localparam int ERR_W   = 4;
    localparam int ERR_MAX = 4;
    localparam int ADC_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ENCODE = 2'd3
    } state_t;

    typedef logic signed [ERR_W-1:0] err_code_t;

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// ADC handshake, loop enable and error-code bundle of the sampling controller.
interface adc_sample_ctrl_if;
    import buck_pkg::*;

    logic             en;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic             adc_start;
    logic             period_sync;
    err_code_t        err_code;
    logic             err_valid;
    logic             fault;
    logic [7:0]       fault_cnt;

    // Controller side
    modport master (
        input  en, adc_done, adc_data,
        output adc_start, period_sync, err_code, err_valid, fault, fault_cnt
    );

    // ADC / loop environment side
    modport slave (
        output en, adc_done, adc_data,
        input  adc_start, period_sync, err_code, err_valid, fault, fault_cnt
    );

endinterface

// File: rtl/err_quantizer.sv
// Combinational quantizer: ((REF + 2) - sample) >>> 2, saturated to +/-ERR_MAX.
module err_quantizer
    import buck_pkg::*;
#(
    parameter int REF = 128
) (
    input  logic [ADC_W-1:0] adc_data,
    output err_code_t        err_code
);

    localparam logic signed [9:0] BIAS     = 10'(REF + 2);
    localparam logic signed [9:0] Q_MAX    = 10'(ERR_MAX);
    localparam err_code_t         CODE_MAX = ERR_W'(ERR_MAX);
    localparam err_code_t         CODE_MIN = ERR_W'(-ERR_MAX);

    logic signed [9:0] diff;
    logic signed [9:0] quo;

    // Subtract, floor-divide by 4, clamp to the code range
    always_comb begin
        diff = BIAS - $signed({2'b00, adc_data});
        quo  = diff >>> 2;
        if (quo > Q_MAX) begin
            err_code = CODE_MAX;
        end else if (quo < -Q_MAX) begin
            err_code = CODE_MIN;
        end else begin
            err_code = quo[ERR_W-1:0];
        end
    end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Per-period ADC sampling controller: timebase, conversion handshake,
// error quantization and timeout fault counting.
module adc_sample_ctrl
    import buck_pkg::*;
#(
    parameter int PERIOD    = 64,
    parameter int SAMPLE_PT = 32,
    parameter int TIMEOUT   = 16,
    parameter int REF       = 128
) (
    input  logic               clk,
    input  logic               rst,
    adc_sample_ctrl_if.master  bus
);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       fault_cnt_q, fault_cnt_d;
    logic [ADC_W-1:0] sample_q, sample_d;
    logic             adc_start_q, adc_start_d;
    logic             period_sync_q, period_sync_d;
    logic             err_valid_w;
    logic             fault_w;
    logic             done_ok;
    logic             expire;
    err_code_t        code_w;

    assign done_ok = (state_q == ST_WAIT) && bus.en && bus.adc_done;
    assign expire  = (state_q == ST_WAIT) && bus.en && !bus.adc_done
                     && (wait_q == 8'(TIMEOUT));

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wait_q        <= '0;
            fault_cnt_q   <= '0;
            sample_q      <= ADC_W'(REF);
            adc_start_q   <= 1'b0;
            period_sync_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            fault_cnt_q   <= fault_cnt_d;
            sample_q      <= sample_d;
            adc_start_q   <= adc_start_d;
            period_sync_q <= period_sync_d;
        end
    end

    // Next-state logic; dropping en aborts from any state
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_ARMED;
                ST_ARMED:  if (cnt_q == 8'(SAMPLE_PT)) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (bus.adc_done) begin
                        state_d = ST_ENCODE;
                    end else if (wait_q == 8'(TIMEOUT)) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ENCODE: state_d = ST_ARMED;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: registered start request, strobe while in ENCODE, timeout pulse
    always_comb begin
        adc_start_d = (state_q == ST_ARMED) && bus.en && (cnt_q == 8'(SAMPLE_PT));
        err_valid_w = (state_q == ST_ENCODE);
        fault_w     = expire;
    end

    // Period/wait counters, sample capture, saturating fault count
    always_comb begin
        if (!bus.en || cnt_q == 8'(PERIOD - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        wait_d        = (state_q == ST_WAIT) ? wait_q + 8'd1 : '0;
        sample_d      = done_ok ? bus.adc_data : sample_q;
        fault_cnt_d   = (expire && fault_cnt_q != '1) ? fault_cnt_q + 8'd1 : fault_cnt_q;
        period_sync_d = bus.en && (cnt_q == '0);
    end

    // err_code is decoded from the held sample; resetting the sample to REF
    // makes the reset code 0 and keeps the code stable between strobes.
    err_quantizer #(.REF(REF)) u_quant (
        .adc_data (sample_q),
        .err_code (code_w)
    );

    assign bus.adc_start   = adc_start_q;
    assign bus.period_sync = period_sync_q;
    assign bus.err_code    = code_w;
    assign bus.err_valid   = err_valid_w;
    assign bus.fault       = fault_w;
    assign bus.fault_cnt   = fault_cnt_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Scoreboard bench for adc_sample_ctrl: stimulus pushes expected events,
// a negedge monitor pops them on err_valid / fault.
module tb_adc_sample_ctrl;

    typedef struct {
        bit         is_fault;
        logic [3:0] code;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    int   off      = 0;
    int   since_start = 0;
    logic [3:0] last_code = 4'b0000;
    exp_t q[$];

    adc_sample_ctrl_if bus();

    adc_sample_ctrl #(
        .PERIOD    (64),
        .SAMPLE_PT (32),
        .TIMEOUT   (16),
        .REF       (128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected codes from the documented sample-range table
    function automatic logic [3:0] range_code(input int v);
        if (v <= 114) return 4'b0100;
        if (v <= 118) return 4'b0011;
        if (v <= 122) return 4'b0010;
        if (v <= 126) return 4'b0001;
        if (v <= 130) return 4'b0000;
        if (v <= 134) return 4'b1111;
        if (v <= 138) return 4'b1110;
        if (v <= 142) return 4'b1101;
        return 4'b1100;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int n = 0;
        tick();
        while (!bus.adc_start && n < 300) begin
            tick();
            n++;
        end
        if (!bus.adc_start) chk("adc_start_timeout", 32'd0, 32'd1);
        start_cyc = cyc;
    endtask

    // ADC model: adc_done lat cycles after adc_start is seen
    task automatic conv_from_start(input logic [7:0] d, input int lat, input logic [3:0] code);
        exp_t e;
        repeat (lat) tick();
        bus.adc_done = 1'b1;
        bus.adc_data = d;
        e.is_fault = 1'b0;
        e.code     = code;
        q.push_back(e);
        last_code = code;
        tick();
        bus.adc_done = 1'b0;
    endtask

    task automatic conv(input logic [7:0] d, input int lat, input logic [3:0] code);
        wait_start();
        conv_from_start(d, lat, code);
    endtask

    task automatic expect_timeout();
        exp_t e;
        wait_start();
        e.is_fault = 1'b1;
        e.code     = last_code;
        q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] ec;
        if (!rst) begin
            ec = bus.err_code;
            off = bus.period_sync ? 0 : off + 1;
            since_start = bus.adc_start ? 0 : since_start + 1;
            if (bus.adc_start) chk("start_offset", off, 32);
            if (bus.err_valid) begin
                if (q.size() == 0 || q[0].is_fault) begin
                    chk("unexpected_err_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("err_code", ec, e.code);
                end
            end
            if (bus.fault) begin
                if (q.size() == 0 || !q[0].is_fault) begin
                    chk("unexpected_fault", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("fault_delay", since_start, 16);
                    chk("fault_code_held", ec, e.code);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] spot_d [14]  = '{114, 115, 126, 131, 142, 143, 255, 0, 127, 130, 123, 119, 135, 139};
        logic [3:0] spot_c [14]  = '{4'b0100, 4'b0011, 4'b0001, 4'b1111, 4'b1101, 4'b1100, 4'b1100,
                                     4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b1110, 4'b1101};
        logic [3:0] ec;
        int t0, n;
        bit bad;

        rst = 1'b1;
        bus.en = 1'b0;
        bus.adc_done = 1'b0;
        bus.adc_data = '0;
        repeat (3) @(posedge clk);
        #1;
        ec = bus.err_code;
        chk("rst_adc_start", bus.adc_start, 0);
        chk("rst_period_sync", bus.period_sync, 0);
        chk("rst_err_code", ec, 4'b0000);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_fault_cnt", bus.fault_cnt, 0);
        rst = 1'b0;
        tick();
        tick();

        // Nominal conversions, one start per 64 cycles
        bus.en = 1'b1;
        tick();
        chk("first_sync", bus.period_sync, 1);
        conv(8'd128, 3, 4'b0000);
        t0 = start_cyc;
        conv(8'd128, 3, 4'b0000);
        chk("start_spacing", start_cyc - t0, 64);

        // Directed spot vectors
        for (int i = 0; i < 14; i++) conv(spot_d[i], 3, spot_c[i]);

        // Full sweep against the range table
        for (int v = 0; v < 256; v++) conv(8'(v), 2, range_code(v));

        // Spurious adc_done while ARMED
        tick();
        bus.adc_done = 1'b1;
        bus.adc_data = 8'd0;
        tick();
        bus.adc_done = 1'b0;
        repeat (3) tick();
        ec = bus.err_code;
        chk("spurious_code_held", ec, last_code);

        // adc_done in the expiry cycle wins over the timeout
        conv(8'd131, 16, 4'b1111);
        repeat (3) tick();
        chk("boundary_fault_cnt", bus.fault_cnt, 0);

        // Timeouts: first one, then saturate
        expect_timeout();
        repeat (18) tick();
        chk("fault_cnt_one", bus.fault_cnt, 1);
        for (int i = 0; i < 299; i++) expect_timeout();
        repeat (20) tick();
        chk("fault_cnt_sat", bus.fault_cnt, 255);

        // Abort by dropping en during WAIT
        wait_start();
        repeat (2) tick();
        bus.en = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.adc_start || bus.period_sync) bad = 1'b1;
        end
        chk("abort_quiet", bad, 0);
        chk("abort_fault_cnt", bus.fault_cnt, 255);
        ec = bus.err_code;
        chk("abort_code_held", ec, last_code);

        // Re-enable: sync next cycle, start at the sample point
        bus.en = 1'b1;
        tick();
        chk("resync", bus.period_sync, 1);
        n = 0;
        while (!bus.adc_start && n < 100) begin
            tick();
            n++;
        end
        chk("restart_offset", n, 32);
        conv_from_start(8'd200, 3, 4'b1100);

        // Asynchronous reset in the middle of WAIT
        wait_start();
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        ec = bus.err_code;
        chk("mid_rst_adc_start", bus.adc_start, 0);
        chk("mid_rst_period_sync", bus.period_sync, 0);
        chk("mid_rst_err_code", ec, 4'b0000);
        chk("mid_rst_err_valid", bus.err_valid, 0);
        chk("mid_rst_fault", bus.fault, 0);
        chk("mid_rst_fault_cnt", bus.fault_cnt, 0);
        q.delete();
        last_code = 4'b0000;
        repeat (2) tick();
        rst = 1'b0;
        conv(8'd120, 3, 4'b0010);
        conv(8'd150, 5, 4'b1100);

        repeat (4) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
